// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RISC-V pipeline: load-use bubbles, taken-branch
// flushes and data-memory wait states, with stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      id_instr,
    input  logic             ex_branch_taken,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // state    | meaning
    // RUN      | normal flow; branch flush / load-use bubble resolved here
    // MEM_WAIT | MEM access outstanding, whole pipe frozen, timeout counting

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(MEM_TIMEOUT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state;
    logic            ex_is_load, ex_is_mem, ex_is_branch, mem_is_mem;
    logic [4:0]      ex_rd;
    logic [TW-1:0]   tcnt, tcnt_nxt;

    logic            id_is_load, id_is_mem, id_is_branch;
    logic            id_use_rs1, id_use_rs2, id_wr_rd;
    logic [4:0]      id_rd, id_rs1, id_rs2;
    logic            hold, br_flush, load_use;
    logic            unused_bits;

    assign id_rd       = id_instr[11:7];
    assign id_rs1      = id_instr[19:15];
    assign id_rs2      = id_instr[24:20];
    assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

    always_comb begin
        id_is_load   = 1'b0;
        id_is_mem    = 1'b0;
        id_is_branch = 1'b0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        id_wr_rd     = 1'b0;
        case (id_instr[6:0])
            OP_LOAD:   begin id_is_load = 1'b1; id_is_mem = 1'b1; id_use_rs1 = 1'b1; id_wr_rd = 1'b1; end
            OP_STORE:  begin id_is_mem = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; end
            OP_BRANCH: begin id_is_branch = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; end
            OP_IMM:    begin id_use_rs1 = 1'b1; id_wr_rd = 1'b1; end
            OP_REG:    begin id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_wr_rd = 1'b1; end
            default:   ;
        endcase
    end

    assign hold     = (state == MEM_WAIT) ? !dmem_ready : (mem_is_mem && !dmem_ready);
    assign br_flush = ex_is_branch && ex_branch_taken;
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign dmem_req = mem_is_mem;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (hold) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (br_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // First frozen cycle counts as 1; the counter then saturates at the timeout.
    always_comb begin
        tcnt_nxt = tcnt;
        if (state == RUN)
            tcnt_nxt = TW'(1);
        else if (tcnt != T_MAX)
            tcnt_nxt = tcnt + TW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            tcnt         <= '0;
            mem_err      <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            ex_is_load   <= 1'b0;
            ex_is_mem    <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_rd        <= 5'd0;
            mem_is_mem   <= 1'b0;
        end else begin
            if (!pc_en)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!hold && br_flush)
                flush_cnt <= flush_cnt + CNT_W'(1);

            if (hold) begin
                state <= MEM_WAIT;
                tcnt  <= tcnt_nxt;
                if (tcnt_nxt == T_MAX)
                    mem_err <= 1'b1;
            end else begin
                state <= RUN;
            end

            if (id_ex_flush) begin
                ex_is_load   <= 1'b0;
                ex_is_mem    <= 1'b0;
                ex_is_branch <= 1'b0;
                ex_rd        <= 5'd0;
            end else if (id_ex_en) begin
                ex_is_load   <= id_is_load;
                ex_is_mem    <= id_is_mem;
                ex_is_branch <= id_is_branch;
                ex_rd        <= id_wr_rd ? id_rd : 5'd0;
            end

            if (ex_mem_en)
                mem_is_mem <= ex_is_mem;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: instruction-level pipeline model checked every cycle,
// directed hazard scenarios with literal expectations, then randomized traffic.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [31:0]      id_instr = NOP;
    logic             ex_branch_taken = 1'b0;
    logic             dmem_ready = 1'b1;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, dmem_req, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_instr(id_instr),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dmem_req(dmem_req), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    logic [7:0] dut_ctl;
    assign dut_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, dmem_req};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction classes straight from the opcode table.
    function automatic bit is_load(input logic [31:0] i);  return i[6:0] == 7'b0000011; endfunction
    function automatic bit is_store(input logic [31:0] i); return i[6:0] == 7'b0100011; endfunction
    function automatic bit is_br(input logic [31:0] i);    return i[6:0] == 7'b1100011; endfunction
    function automatic bit is_memop(input logic [31:0] i); return is_load(i) || is_store(i); endfunction
    function automatic bit reads_rs1(input logic [31:0] i);
        return is_memop(i) || is_br(i) || i[6:0] == 7'b0010011 || i[6:0] == 7'b0110011;
    endfunction
    function automatic bit reads_rs2(input logic [31:0] i);
        return is_store(i) || is_br(i) || i[6:0] == 7'b0110011;
    endfunction
    function automatic bit depends_on(input logic [31:0] i, input logic [4:0] r);
        return (r != 5'd0) && ((reads_rs1(i) && i[19:15] == r) || (reads_rs2(i) && i[24:20] == r));
    endfunction

    function automatic logic [31:0] i_ld(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_beq(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 6))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b1100011;
            3: op = 7'b0010011;
            4: op = 7'b0110011;
            5: op = 7'b1101111;
            default: op = 7'b0110111;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    // Model: the actual instruction words occupying EX and MEM (0 = empty slot).
    typedef enum {FLOW, BUBBLE, FLUSH, FREEZE} act_t;
    logic [31:0]      m_ex = '0, m_mem = '0;
    bit               m_waiting = 1'b0, m_err = 1'b0;
    int               m_low = 0, m_low_next;
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
    act_t             m_act;
    logic [7:0]       e_ctl;

    always_comb begin
        m_act = FLOW;
        if (is_memop(m_mem) && !dmem_ready)
            m_act = FREEZE;
        else if (is_br(m_ex) && ex_branch_taken)
            m_act = FLUSH;
        else if (is_load(m_ex) && depends_on(id_instr, m_ex[11:7]))
            m_act = BUBBLE;
        case (m_act)
            FREEZE:  e_ctl = 8'b00000_00_0;
            FLUSH:   e_ctl = 8'b11111_11_0;
            BUBBLE:  e_ctl = 8'b00111_01_0;
            default: e_ctl = 8'b11111_00_0;
        endcase
        e_ctl[0] = is_memop(m_mem);
        m_low_next = m_waiting ? ((m_low >= MEM_TIMEOUT) ? MEM_TIMEOUT : m_low + 1) : 1;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ex <= '0; m_mem <= '0; m_waiting <= 1'b0; m_err <= 1'b0;
            m_low <= 0; m_stall <= '0; m_flush <= '0;
        end else begin
            if (m_act == FREEZE || m_act == BUBBLE)
                m_stall <= m_stall + 1;
            if (m_act == FLUSH)
                m_flush <= m_flush + 1;
            if (m_act == FREEZE) begin
                m_waiting <= 1'b1;
                m_low     <= m_low_next;
                if (m_low_next >= MEM_TIMEOUT)
                    m_err <= 1'b1;
            end else begin
                m_waiting <= 1'b0;
                m_mem     <= m_ex;
                m_ex      <= (m_act == FLOW) ? id_instr : 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        check("ctl", 32'(dut_ctl), 32'(e_ctl));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end

    task automatic step(input logic [31:0] ins, input logic tk, input logic rdy);
        @(posedge clk);
        #1;
        id_instr = ins; ex_branch_taken = tk; dmem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0; id_instr = NOP; ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int lowrun = 0;
    logic rdy;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst_ctl", 32'(dut_ctl), 32'h0000_00F8);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);

        // lw x5,0(x1) then add x6,x5,x2
        step(i_ld(5, 1), 1'b0, 1'b1);
        step(i_add(6, 5, 2), 1'b0, 1'b1);
        check("lu_pc_en", 32'(pc_en), 32'd0);
        check("lu_if_id_en", 32'(if_id_en), 32'd0);
        check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("lu_ex_mem_en", 32'(ex_mem_en), 32'd1);
        step(i_add(6, 5, 2), 1'b0, 1'b1);
        check("lu_resume_pc_en", 32'(pc_en), 32'd1);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // load to x0 never stalls
        do_reset();
        step(i_ld(0, 1), 1'b0, 1'b1);
        step(i_add(6, 0, 2), 1'b0, 1'b1);
        check("x0_pc_en", 32'(pc_en), 32'd1);
        step(NOP, 1'b0, 1'b1);
        check("x0_stall_cnt", 32'(stall_cnt), 32'd0);

        // taken branch, then taken flag with a non-branch in EX
        do_reset();
        step(i_beq(1, 2), 1'b0, 1'b1);
        step(NOP, 1'b1, 1'b1);
        check("br_ctl", 32'(dut_ctl), 32'h0000_00FE);
        step(NOP, 1'b0, 1'b1);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        step(i_add(7, 1, 2), 1'b0, 1'b1);
        step(NOP, 1'b1, 1'b1);
        check("nobr_ctl", 32'(dut_ctl), 32'h0000_00F8);
        step(NOP, 1'b0, 1'b1);
        check("nobr_flush_cnt", 32'(flush_cnt), 32'd1);

        // three-cycle memory wait
        do_reset();
        step(i_ld(5, 1), 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(NOP, 1'b0, 1'b0);
            check("mw_ctl", 32'(dut_ctl), 32'h0000_0001);
        end
        step(NOP, 1'b0, 1'b1);
        check("mw_resume_ctl", 32'(dut_ctl), 32'h0000_00F9);
        check("mw_mem_err", 32'(mem_err), 32'd0);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);

        // 20 not-ready cycles: error visible after the 16th
        do_reset();
        step(i_ld(5, 1), 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            step(NOP, 1'b0, 1'b0);
            check("to_mem_err", 32'(mem_err), (i >= MEM_TIMEOUT + 1) ? 32'd1 : 32'd0);
        end
        step(NOP, 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        check("to_sticky", 32'(mem_err), 32'd1);

        // taken branch pending behind a memory wait, dependent add in ID
        do_reset();
        step(i_ld(5, 1), 1'b0, 1'b1);
        step(i_beq(1, 2), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i_add(6, 5, 2), 1'b1, 1'b0);
            check("pri_freeze_ctl", 32'(dut_ctl), 32'h0000_0001);
        end
        step(i_add(6, 5, 2), 1'b1, 1'b1);
        check("pri_flush_ctl", 32'(dut_ctl), 32'h0000_00FF);
        step(NOP, 1'b0, 1'b1);
        check("pri_flush_cnt", 32'(flush_cnt), 32'd1);
        check("pri_stall_cnt", 32'(stall_cnt), 32'd3);

        // asynchronous reset in the middle of a timed-out wait
        do_reset();
        step(i_ld(5, 1), 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(NOP, 1'b0, 1'b0);
        check("rmw_pre_err", 32'(mem_err), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rmw_ctl", 32'(dut_ctl), 32'h0000_00F8);
        check("rmw_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rmw_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rmw_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // randomized traffic with occasional long not-ready runs and resets
        repeat (3000) begin
            if (lowrun > 0) begin
                rdy = 1'b0;
                lowrun--;
            end else if ($urandom_range(0, 49) == 0) begin
                rdy = 1'b0;
                lowrun = $urandom_range(10, 24);
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            step(rand_instr(), 1'($urandom_range(0, 1)), rdy);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined RISC-V core (IF/ID/EX/MEM/WB).
- Decodes the instruction sitting in IF/ID and keeps its own shadow of EX- and MEM-stage occupancy (is_load, is_mem, is_branch, rd).
- Drives per-stage register enables and flushes.
- Resolves load-use hazards, taken-branch flushes, and data-memory wait states, and counts stall cycles.

Parameters:
- MEM_TIMEOUT, 16, consecutive not-ready cycles in MEM_WAIT after which mem_err sets.
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_instr  in  32  instruction currently in IF/ID.
- ex_branch_taken  in  1  branch comparator result from EX.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_en  out  1  PC register write enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble into ID/EX.
- dmem_req  out  1  MEM stage holds a load/store.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Opcode classes from id_instr[6:0]:
  - LOAD 0000011: uses rs1.
  - STORE 0100011: uses rs1, rs2.
  - BRANCH 1100011: uses rs1, rs2.
  - OP-IMM 0010011: uses rs1.
  - OP 0110011: uses rs1, rs2.
  - Anything else: no source registers, no rd.
  - rd is written only for LOAD, OP-IMM and OP. rd = id_instr[11:7], rs1 = [19:15], rs2 = [24:20].
- Shadow registers ex_{is_load,is_mem,is_branch,rd} and mem_is_mem:
  - Update only when the matching stage enable is 1.
  - When id_ex_flush=1, the EX shadow is cleared to zeros.
  - mem_is_mem <= ex_is_mem when ex_mem_en=1.
- dmem_req = mem_is_mem (combinational from shadow).
- States: RUN and MEM_WAIT.
- Priority, evaluated each cycle in RUN:
  1. MEM wait: mem_is_mem=1 and dmem_ready=0.
     - All five enables = 0, both flushes = 0.
     - Next state MEM_WAIT; timeout counter <= 1.
  2. Branch flush: ex_is_branch=1 and ex_branch_taken=1.
     - All enables = 1; if_id_flush = id_ex_flush = 1.
     - flush_cnt increments.
     - ex_branch_taken is ignored when ex_is_branch=0.
  3. Load-use: ex_is_load=1, ex_rd!=0, and ex_rd equals a used source register of id_instr.
     - pc_en = if_id_en = 0; id_ex_flush = 1; remaining enables = 1.
     - Resolves in exactly one cycle because the bubble clears ex_is_load.
  4. Otherwise: all enables = 1, flushes = 0.
- MEM_WAIT:
  - All enables = 0 and flushes = 0 while dmem_ready=0; timeout counter increments, saturating.
  - When the counter reaches MEM_TIMEOUT, mem_err <= 1. It is sticky until reset. Stalling continues.
  - When dmem_ready=1: return to RUN and, in that same cycle, apply the rules above as if in RUN with rule 1 satisfied. This lets a pending branch or load-use act immediately.
- Simultaneous events:
  - Branch flush overrides load-use, since the ID instruction is discarded anyway.
  - MEM wait overrides both; branch and load-use conditions stay pending in the frozen shadows.
- stall_cnt increments every cycle pc_en=0, wraps at 2^CNT_W.
- Reset (asynchronous, any time, including mid-MEM_WAIT):
  - State = RUN; all shadows = 0; counters = 0; mem_err = 0.
  - Outputs then evaluate to: all enables = 1, flushes = 0, dmem_req = 0.
- Outputs are combinational from state, shadows, id_instr, ex_branch_taken and dmem_ready. No extra latency.

Test Plan:
- Load then dependent use: lw x5,0(x1) followed by add x6,x5,x2, dmem_ready=1.
  - Exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
  - add proceeds next cycle.
- Load to x0: lw x0,0(x1) then add x6,x0,x2 → no stall; stall_cnt=0.
- Taken branch: beq in EX with ex_branch_taken=1.
  - if_id_flush=1, id_ex_flush=1, pc_en=1 for one cycle; flush_cnt=1.
  - Same stimulus with a non-branch in EX → no flush.
- Memory wait: load reaches MEM with dmem_ready low for 3 cycles.
  - All enables 0 for 3 cycles, dmem_req=1; resume on the 4th cycle; mem_err=0.
  - Same with ready low for 20 cycles (MEM_TIMEOUT=16) → mem_err rises on cycle 16 and stays 1 after ready.
- Priority: taken branch in EX while ID holds a load-use dependent → flush only, no load-use stall.
  - Same combination during a MEM wait → full freeze until ready, then flush.
- Reset pulse mid-MEM_WAIT: reset_n low for 1 cycle.
  - Immediately: state RUN, all enables=1, dmem_req=0, stall_cnt=0, flush_cnt=0, mem_err=0.
